// File: rtl/dmac_nch.sv
// dmac_nch: N-channel dual-address DMA controller with fixed/round-robin arbitration,
// 16-byte unit buffering, byte/word lane steering and per-channel TCR auto-reload.
module dmac_nch #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned TCW  = 24,
  parameter int unsigned BUFD = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           CE,
  input  logic           NMI_N,
  input  logic [NCH-1:0] DREQ,
  output logic [NCH-1:0] DACK,
  input  logic [7:0]     REG_A,
  input  logic [31:0]    REG_DI,
  input  logic           REG_WE,
  input  logic           REG_REQ,
  output logic [31:0]    REG_DO,
  output logic [31:0]    BUS_A,
  output logic [31:0]    BUS_DO,
  input  logic [31:0]    BUS_DI,
  output logic [3:0]     BUS_BA,
  output logic           BUS_WE,
  output logic           BUS_REQ,
  output logic           BUS_LOCK,
  input  logic           BUS_WAIT,
  output logic [NCH-1:0] IRQ
);
  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned BW = $clog2(BUFD);

  typedef enum logic [2:0] {IDLE, ARB, READ, WRITE, UPDATE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    sar_q [NCH], sar_d [NCH], dar_q [NCH], dar_d [NCH];
  logic [TCW-1:0] tcr_q [NCH], tcr_d [NCH], rld_q [NCH], rld_d [NCH];
  logic [15:0]    chcr_q [NCH], chcr_d [NCH];
  logic [31:0]    buf_q [BUFD], buf_d [BUFD];
  logic           dme_q, dme_d, pr_q, pr_d, ae_q, ae_d, nmif_q, nmif_d;
  logic [CW-1:0]  ch_q, ch_d, last_q, last_d, win, cand;
  logic [BW-1:0]  beat_q, beat_d;
  logic [1:0]     sofs_q, sofs_d, ts, rk;
  logic [NCH-1:0] dreq_q, elat_q, elat_d, qual, clr_elat;
  logic [31:0]    reg_do_q, reg_do_d;
  logic [15:0]    cc;
  logic [TCW-1:0] tdec;
  logic [63:0]    dd;
  logic           found, active, last_beat, beat_done, set_te, set_ae, src;

  function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] mode,
                                       input logic [1:0] tsz);
    logic [31:0] sz;
    sz = (tsz == 2'b00) ? 32'd1 : (tsz == 2'b01) ? 32'd2 : 32'd4;
    if (tsz == 2'b11) return a + 32'd4;
    case (mode)
      2'b01:   return a + sz;
      2'b10:   return a - sz;
      default: return a;
    endcase
  endfunction

  function automatic logic misaligned(input logic [31:0] s, input logic [31:0] d,
                                      input logic [1:0] tsz);
    logic [3:0] m;
    case (tsz)
      2'b00:   m = 4'h0;
      2'b01:   m = 4'h1;
      2'b10:   m = 4'h3;
      default: m = 4'hF;
    endcase
    return |((s[3:0] | d[3:0]) & m);
  endfunction

  assign cc        = chcr_q[ch_q];
  assign ts        = cc[11:10];
  assign active    = (state_q == READ) || (state_q == WRITE);
  assign last_beat = (ts == 2'b11) ? (beat_q == BW'(3)) : 1'b1;
  assign beat_done = BUS_REQ & ~BUS_WAIT;
  assign REG_DO    = reg_do_q;

  always_comb begin
    qual = '0;
    src  = 1'b0;
    for (int unsigned n = 0; n < NCH; n++) begin
      src = chcr_q[n][9] | (chcr_q[n][7] ? elat_q[n] : (DREQ[n] == chcr_q[n][6]));
      qual[n] = dme_q & chcr_q[n][0] & ~chcr_q[n][1] & ~nmif_q & ~ae_q & src;
    end
  end

  // Round-robin search starts one past the previous winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = pr_q ? CW'((32'(last_q) + 32'd1 + i) % NCH) : CW'(i);
      if (!found && qual[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;  ch_d = ch_q;  last_d = last_q;  beat_d = beat_q;  sofs_d = sofs_q;
    sar_d = sar_q;  dar_d = dar_q;  tcr_d = tcr_q;  rld_d = rld_q;  chcr_d = chcr_q;
    buf_d = buf_q;  dme_d = dme_q;  pr_d = pr_q;  ae_d = ae_q;  nmif_d = nmif_q;
    clr_elat = '0;  set_te = 1'b0;  set_ae = 1'b0;  reg_do_d = reg_do_q;  elat_d = '0;
    tdec = tcr_q[ch_q] - TCW'(1);
    case (state_q)
      IDLE: if (|qual) state_d = ARB;
      ARB: begin
        if (!found) state_d = IDLE;
        else begin
          ch_d   = win;
          last_d = win;
          if (misaligned(sar_q[win], dar_q[win], chcr_q[win][11:10])) begin
            set_ae  = 1'b1;
            state_d = IDLE;
          end else begin
            clr_elat[win] = 1'b1;
            beat_d        = '0;
            state_d       = READ;
          end
        end
      end
      READ: if (beat_done) begin
        buf_d[beat_q] = BUS_DI;
        sofs_d        = sar_q[ch_q][1:0];
        sar_d[ch_q]   = step(sar_q[ch_q], cc[13:12], ts);
        beat_d        = last_beat ? '0 : beat_q + BW'(1);
        if (last_beat) state_d = WRITE;
      end
      WRITE: if (beat_done) begin
        dar_d[ch_q] = step(dar_q[ch_q], cc[15:14], ts);
        beat_d      = last_beat ? '0 : beat_q + BW'(1);
        if (last_beat) state_d = UPDATE;
      end
      UPDATE: begin
        tcr_d[ch_q] = tdec;
        if (tdec == '0) begin
          if (cc[4]) tcr_d[ch_q] = rld_q[ch_q];
          else       set_te = 1'b1;
        end
        if (cc[5] && qual[ch_q] && !set_te) begin
          clr_elat[ch_q] = 1'b1;
          beat_d         = '0;
          state_d        = READ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Register writes override same-cycle hardware updates; hardware flag sets win over clears.
    if (REG_REQ && REG_WE) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        if (REG_A == 8'(16*n))          sar_d[n] = REG_DI;
        if (REG_A == 8'(16*n+4))        dar_d[n] = REG_DI;
        if (REG_A == 8'(16*n+8))        tcr_d[n] = REG_DI[TCW-1:0];
        if (REG_A == 8'(16*n+12))       chcr_d[n] = {REG_DI[15:2], chcr_q[n][1] & REG_DI[1], REG_DI[0]};
        if (REG_A == 8'(16*NCH+4+4*n))  rld_d[n] = REG_DI[TCW-1:0];
      end
      if (REG_A == 8'(16*NCH)) begin
        dme_d  = REG_DI[0];
        nmif_d = nmif_q & REG_DI[1];
        ae_d   = ae_q & REG_DI[2];
        pr_d   = REG_DI[3];
      end
    end
    if (set_te) chcr_d[ch_q][1] = 1'b1;
    if (set_ae) ae_d = 1'b1;
    if (!NMI_N) nmif_d = 1'b1;

    if (REG_REQ && !REG_WE) begin
      reg_do_d = '0;
      for (int unsigned n = 0; n < NCH; n++) begin
        if (REG_A == 8'(16*n))          reg_do_d = sar_q[n];
        if (REG_A == 8'(16*n+4))        reg_do_d = dar_q[n];
        if (REG_A == 8'(16*n+8))        reg_do_d = 32'(tcr_q[n]);
        if (REG_A == 8'(16*n+12))       reg_do_d = {16'h0, chcr_q[n]};
        if (REG_A == 8'(16*NCH+4+4*n))  reg_do_d = 32'(rld_q[n]);
      end
      if (REG_A == 8'(16*NCH)) reg_do_d = {28'h0, pr_q, ae_q, nmif_q, dme_q};
    end

    for (int unsigned n = 0; n < NCH; n++)
      elat_d[n] = (elat_q[n] & ~clr_elat[n]) |
                  (chcr_q[n][6] ? (DREQ[n] & ~dreq_q[n]) : (~DREQ[n] & dreq_q[n]));
  end

  always_comb begin
    BUS_REQ  = active;
    BUS_WE   = (state_q == WRITE);
    BUS_LOCK = active && (ts == 2'b11);
    BUS_A    = '0;
    BUS_BA   = '0;
    BUS_DO   = '0;
    rk       = dar_q[ch_q][1:0] - sofs_q;
    dd       = {buf_q[0], buf_q[0]} >> {rk, 3'b000};
    if (active) begin
      BUS_A = (state_q == READ) ? sar_q[ch_q] : dar_q[ch_q];
      case (ts)
        2'b00:   BUS_BA = 4'b1000 >> BUS_A[1:0];
        2'b01:   BUS_BA = BUS_A[1] ? 4'b0011 : 4'b1100;
        default: BUS_BA = 4'b1111;
      endcase
    end
    if (state_q == WRITE) BUS_DO = (ts == 2'b11) ? buf_q[beat_q] : dd[31:0];
    for (int unsigned n = 0; n < NCH; n++) begin
      DACK[n] = chcr_q[n][8] ^ (active && (ch_q == CW'(n)) &&
                ((state_q == READ && chcr_q[n][13:12] == 2'b00) ||
                 (state_q == WRITE && chcr_q[n][15:14] == 2'b00)));
      IRQ[n]  = chcr_q[n][1] & chcr_q[n][2];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;  ch_q <= '0;  last_q <= CW'(NCH-1);  beat_q <= '0;  sofs_q <= '0;
      dme_q <= 1'b0;  pr_q <= 1'b0;  ae_q <= 1'b0;  nmif_q <= 1'b0;
      dreq_q <= '0;  elat_q <= '0;  reg_do_q <= '0;
      for (int unsigned n = 0; n < NCH; n++) begin
        sar_q[n] <= '0;  dar_q[n] <= '0;  tcr_q[n] <= '0;  rld_q[n] <= '0;  chcr_q[n] <= '0;
      end
      for (int unsigned k = 0; k < BUFD; k++) buf_q[k] <= '0;
    end else if (CE) begin
      state_q <= state_d;  ch_q <= ch_d;  last_q <= last_d;  beat_q <= beat_d;  sofs_q <= sofs_d;
      dme_q <= dme_d;  pr_q <= pr_d;  ae_q <= ae_d;  nmif_q <= nmif_d;
      dreq_q <= DREQ;  elat_q <= elat_d;  reg_do_q <= reg_do_d;
      sar_q <= sar_d;  dar_q <= dar_d;  tcr_q <= tcr_d;  rld_q <= rld_d;  chcr_q <= chcr_d;
      buf_q <= buf_d;
    end
  end
endmodule
